// File: rtl/timer_pkg.sv
// Shared definitions for the timer blocks (countdown_timer, stopwatch).
// Contents: FSM state encoding, M/SS/D field widths and limits, and the
// load-value clamp helpers. Optional feature macro used by the countdown
// top: COUNTDOWN_AUTO_RELOAD_EN.
package timer_pkg;
  localparam int M_W    = 4;
  localparam int SS_W   = 6;
  localparam int D_W    = 4;
  localparam int DS_MAX = 9;
  localparam int SS_MAX = 59;
  localparam int M_MAX  = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  function automatic logic [SS_W-1:0] clamp_ss(input logic [SS_W-1:0] v);
    return (v > SS_W'(SS_MAX)) ? SS_W'(SS_MAX) : v;
  endfunction

  function automatic logic [D_W-1:0] clamp_d(input logic [D_W-1:0] v);
    return (v > D_W'(DS_MAX)) ? D_W'(DS_MAX) : v;
  endfunction
endpackage

// File: rtl/bcd_borrow_chain.sv
// Combinational one-decisecond decrement of an M/SS/D time value.
// Ports:
//   m, ss, d           current value
//   m_nx, ss_nx, d_nx  value minus 0:00.1 (only meaningful when !is_zero)
//   is_zero            current value is 0:00.0
//   nx_zero            decremented value is 0:00.0 (next tick expires)
module bcd_borrow_chain
  import timer_pkg::*;
(
  input  logic [M_W-1:0]  m,
  input  logic [SS_W-1:0] ss,
  input  logic [D_W-1:0]  d,
  output logic [M_W-1:0]  m_nx,
  output logic [SS_W-1:0] ss_nx,
  output logic [D_W-1:0]  d_nx,
  output logic            is_zero,
  output logic            nx_zero
);
  logic borrow_ss, borrow_m;

  always_comb begin
    borrow_ss = (d == '0);
    borrow_m  = borrow_ss && (ss == '0);
    d_nx  = borrow_ss ? D_W'(DS_MAX) : d - D_W'(1);
    ss_nx = ss;
    if (borrow_ss) ss_nx = (ss == '0) ? SS_W'(SS_MAX) : ss - SS_W'(1);
    // Callers never decrement 0:00.0, so m cannot underflow here.
    m_nx  = borrow_m ? m - M_W'(1) : m;
    is_zero = (m == '0) && (ss == '0) && (d == '0);
    nx_zero = (m_nx == '0) && (ss_nx == '0) && (d_nx == '0);
  end
endmodule

// File: rtl/countdown_timer.sv
// Down-counting M:SS.D timer. Loaded with a value, counts down one
// decisecond every TICKS_PER_DS clocks while running, pulses done for one
// cycle when it reaches 0:00.0.
// Ports:
//   clk                 clock, rising edge
//   clr                 synchronous active-high reset (highest priority)
//   load                capture clamped M_in/SS_in/D_in, go IDLE
//   start               start/resume counting
//   pause               freeze counting (RUN only)
//   M_in/SS_in/D_in     load value (SS clamps to 59, D clamps to 9)
//   M/SS/D              current value (registered)
//   running             registered, high in RUN
//   done                registered one-cycle expiry pulse
// Optional: COUNTDOWN_AUTO_RELOAD_EN -- on expiry reload the last loaded
// value and keep running (done still pulses); a zero shadow still expires.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int TICKS_PER_DS = 10,
  parameter int PRE_W        = 4
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            load,
  input  logic            start,
  input  logic            pause,
  input  logic [M_W-1:0]  M_in,
  input  logic [SS_W-1:0] SS_in,
  input  logic [D_W-1:0]  D_in,
  output logic [M_W-1:0]  M,
  output logic [SS_W-1:0] SS,
  output logic [D_W-1:0]  D,
  output logic            running,
  output logic            done
);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_DS - 1);

  state_t           state;
  logic [PRE_W-1:0] pre;

  logic [M_W-1:0]  m_nx;
  logic [SS_W-1:0] ss_nx;
  logic [D_W-1:0]  d_nx;
  logic            is_zero, nx_zero;

  bcd_borrow_chain u_chain (
    .m(M), .ss(SS), .d(D),
    .m_nx(m_nx), .ss_nx(ss_nx), .d_nx(d_nx),
    .is_zero(is_zero), .nx_zero(nx_zero)
  );

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [M_W-1:0]  sh_m;
  logic [SS_W-1:0] sh_ss;
  logic [D_W-1:0]  sh_d;
  logic            sh_zero;
  assign sh_zero = (sh_m == '0) && (sh_ss == '0) && (sh_d == '0);

  always_ff @(posedge clk) begin
    if (clr) begin
      sh_m  <= '0;
      sh_ss <= '0;
      sh_d  <= '0;
    end else if (load) begin
      sh_m  <= M_in;
      sh_ss <= clamp_ss(SS_in);
      sh_d  <= clamp_d(D_in);
    end
  end
`endif

  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (clr) begin
      M       <= '0;
      SS      <= '0;
      D       <= '0;
      pre     <= '0;
      state   <= IDLE;
      running <= 1'b0;
    end else if (load) begin
      M       <= M_in;
      SS      <= clamp_ss(SS_in);
      D       <= clamp_d(D_in);
      pre     <= '0;
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      case (state)
        IDLE, PAUSED: begin
          // pre is deliberately kept so a resume finishes the partial tick.
          if (start) begin
            if (is_zero) begin
              state <= EXPIRED;
              done  <= 1'b1;
            end else begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
        end
        RUN: begin
          if (pause) begin
            state   <= PAUSED;
            running <= 1'b0;
          end else if (pre == PRE_LAST) begin
            pre  <= '0;
            M    <= m_nx;
            SS   <= ss_nx;
            D    <= d_nx;
            if (nx_zero) begin
              done <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              if (!sh_zero) begin
                M  <= sh_m;
                SS <= sh_ss;
                D  <= sh_d;
              end else begin
                state   <= EXPIRED;
                running <= 1'b0;
              end
`else
              state   <= EXPIRED;
              running <= 1'b0;
`endif
            end
          end else begin
            pre <= pre + PRE_W'(1);
          end
        end
        default: ; // EXPIRED holds 0:00.0 until load or clr
      endcase
    end
  end
endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;
  logic       clk = 1'b0;
  logic       clr = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [3:0] M_in = '0, D_in = '0;
  logic [5:0] SS_in = '0;
  logic [3:0] M, D;
  logic [5:0] SS;
  logic       running, done;

  int checks = 0;
  int errors = 0;

  countdown_timer #(.TICKS_PER_DS(4), .PRE_W(4)) dut (
    .clk(clk), .clr(clr), .load(load), .start(start), .pause(pause),
    .M_in(M_in), .SS_in(SS_in), .D_in(D_in),
    .M(M), .SS(SS), .D(D), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    bit         c, l, s, p;
    logic [3:0] mi;
    logic [5:0] si;
    logic [3:0] di;
    int         cyc;   // edges to run; inputs only held for the first
    logic [3:0] em;
    logic [5:0] es;
    logic [3:0] ed;
    bit         er, edn;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string name, input bit c, l, s, p,
                     input int mi, si, di, cyc, em, es, ed,
                     input bit er, edn);
    vec_t v;
    v.name = name; v.c = c; v.l = l; v.s = s; v.p = p;
    v.mi = 4'(mi); v.si = 6'(si); v.di = 4'(di); v.cyc = cyc;
    v.em = 4'(em); v.es = 6'(es); v.ed = 4'(ed); v.er = er; v.edn = edn;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] em,
                       input logic [5:0] es, input logic [3:0] ed,
                       input bit er, input bit edn);
    checks++;
    if (M !== em || SS !== es || D !== ed || running !== er || done !== edn) begin
      errors++;
      $display("FAIL %s: got %0d:%0d.%0d run=%0b done=%0b, want %0d:%0d.%0d run=%0b done=%0b",
               name, M, SS, D, running, done, em, es, ed, er, edn);
    end
  endtask

  task automatic drive(input bit c, l, s, p, input logic [3:0] mi,
                       input logic [5:0] si, input logic [3:0] di, input int cyc);
    clr = c; load = l; start = s; pause = p; M_in = mi; SS_in = si; D_in = di;
    for (int k = 0; k < cyc; k++) begin
      @(posedge clk); #1;
      clr = 0; load = 0; start = 0; pause = 0;
    end
  endtask

  initial begin
    int pulses, first_at;

    //   name           c l s p  mi si di cyc  m  ss d  run done
    add("reset",        1,0,0,0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
    add("clamp_load",   0,1,0,0, 3, 63,12,1,   3, 59,9, 0, 0);
    add("idle_hold",    0,0,0,0, 0, 0, 0, 5,   3, 59,9, 0, 0);
`ifndef COUNTDOWN_AUTO_RELOAD_EN
    // 0:01.2 countdown: ticks at 4,8,...,48 edges after start
    add("ld_012",       0,1,0,0, 0, 1, 2, 1,   0, 1, 2, 0, 0);
    add("start_012",    0,0,1,0, 0, 0, 0, 1,   0, 1, 2, 1, 0);
    add("pre_tick",     0,0,0,0, 0, 0, 0, 3,   0, 1, 2, 1, 0);
    add("tick1",        0,0,0,0, 0, 0, 0, 1,   0, 1, 1, 1, 0);
    add("tick2",        0,0,0,0, 0, 0, 0, 4,   0, 1, 0, 1, 0);
    add("borrow_ss",    0,0,0,0, 0, 0, 0, 4,   0, 0, 9, 1, 0);
    add("edge47",       0,0,0,0, 0, 0, 0, 35,  0, 0, 1, 1, 0);
    add("expire48",     0,0,0,0, 0, 0, 0, 1,   0, 0, 0, 0, 1);
    add("done_once",    0,0,0,0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
    add("start_expd",   0,0,1,0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
    add("expd_hold",    0,0,0,0, 0, 0, 0, 6,   0, 0, 0, 0, 0);
    // pause / resume at 0:00.5; paused with pre=1, resume ticks at +3,+7,+11,+15
    add("ld_005",       0,1,0,0, 0, 0, 5, 1,   0, 0, 5, 0, 0);
    add("start_005",    0,0,1,0, 0, 0, 0, 1,   0, 0, 5, 1, 0);
    add("tick_004",     0,0,0,0, 0, 0, 0, 4,   0, 0, 4, 1, 0);
    add("pre1",         0,0,0,0, 0, 0, 0, 1,   0, 0, 4, 1, 0);
    add("pause_wins",   0,0,1,1, 0, 0, 0, 1,   0, 0, 4, 0, 0);
    add("paused_hold",  0,0,0,0, 0, 0, 0, 20,  0, 0, 4, 0, 0);
    add("resume",       0,0,1,0, 0, 0, 0, 1,   0, 0, 4, 1, 0);
    add("partial_tick", 0,0,0,0, 0, 0, 0, 3,   0, 0, 3, 1, 0);
    add("resume_e14",   0,0,0,0, 0, 0, 0, 11,  0, 0, 1, 1, 0);
    add("resume_done",  0,0,0,0, 0, 0, 0, 1,   0, 0, 0, 0, 1);
`endif
    // 1:00.0 borrow through minutes
    add("ld_100",       0,1,0,0, 1, 0, 0, 1,   1, 0, 0, 0, 0);
    add("start_100",    0,0,1,0, 0, 0, 0, 1,   1, 0, 0, 1, 0);
    add("start_in_run", 0,0,1,0, 0, 0, 0, 1,   1, 0, 0, 1, 0);
    add("borrow_m",     0,0,0,0, 0, 0, 0, 3,   0, 59,9, 1, 0);
    add("at_059_0",     0,0,0,0, 0, 0, 0, 36,  0, 59,0, 1, 0);
    add("at_058_9",     0,0,0,0, 0, 0, 0, 4,   0, 58,9, 1, 0);
    add("load_abort",   0,1,0,0, 3, 63,12,1,   3, 59,9, 0, 0);
    // start with zero loaded
    add("ld_zero",      0,1,0,0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
    add("start_zero",   0,0,1,0, 0, 0, 0, 1,   0, 0, 0, 0, 1);
    add("zero_after",   0,0,0,0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
    // clr mid-run
    add("ld_2305",      0,1,0,0, 2, 30,5, 1,   2, 30,5, 0, 0);
    add("start_2305",   0,0,1,0, 0, 0, 0, 3,   2, 30,5, 1, 0);
    add("clr_midrun",   1,0,0,0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
    add("clr_no_done",  0,0,0,0, 0, 0, 0, 8,   0, 0, 0, 0, 0);
    // load mid-run
    add("ld_2305b",     0,1,0,0, 2, 30,5, 1,   2, 30,5, 0, 0);
    add("start_2305b",  0,0,1,0, 0, 0, 0, 6,   2, 30,4, 1, 0);
    add("load_midrun",  0,1,0,0, 0, 7, 0, 1,   0, 7, 0, 0, 0);
    add("idle_no_cnt",  0,0,0,0, 0, 0, 0, 8,   0, 7, 0, 0, 0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // auto reload of 0:00.2: done every 8 edges, stays running
    add("ld_002",       0,1,0,0, 0, 0, 2, 1,   0, 0, 2, 0, 0);
    add("start_002",    0,0,1,0, 0, 0, 0, 1,   0, 0, 2, 1, 0);
    add("ar_tick",      0,0,0,0, 0, 0, 0, 7,   0, 0, 1, 1, 0);
    add("ar_reload1",   0,0,0,0, 0, 0, 0, 1,   0, 0, 2, 1, 1);
    add("ar_after1",    0,0,0,0, 0, 0, 0, 1,   0, 0, 2, 1, 0);
    add("ar_reload2",   0,0,0,0, 0, 0, 0, 7,   0, 0, 2, 1, 1);
    add("ar_clr",       1,0,0,0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
    add("ar_zero_st",   0,0,1,0, 0, 0, 0, 1,   0, 0, 0, 0, 1);
    add("ar_zero_hold", 0,0,0,0, 0, 0, 0, 3,   0, 0, 0, 0, 0);
`endif

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].c, tbl[i].l, tbl[i].s, tbl[i].p,
            tbl[i].mi, tbl[i].si, tbl[i].di, tbl[i].cyc);
      check(tbl[i].name, tbl[i].em, tbl[i].es, tbl[i].ed, tbl[i].er, tbl[i].edn);
    end

    // Hand-written: 0:00.3 must give exactly one done pulse, 12 edges after start,
    // within a 20-edge window (auto reload's second pulse would be at 24).
    drive(0, 1, 0, 0, 4'd0, 6'd0, 4'd3, 1);
    drive(0, 0, 1, 0, 4'd0, 6'd0, 4'd0, 1);
    pulses = 0; first_at = -1;
    for (int k = 1; k <= 20; k++) begin
      drive(0, 0, 0, 0, 4'd0, 6'd0, 4'd0, 1);
      if (done === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = k;
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL done_count: got %0d pulses, want 1", pulses);
    end
    checks++;
    if (first_at != 12) begin
      errors++;
      $display("FAIL done_latency: got edge %0d, want 12", first_at);
    end
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    check("post_window", 4'd0, 6'd0, 4'd1, 1'b1, 1'b0);
`else
    check("post_window", 4'd0, 6'd0, 4'd0, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
